// File: rtl/branch_predict_ctrl_pkg.sv
// rtl/branch_predict_ctrl_pkg.sv - shared encodings for the branch predictor and redirect controller
package branch_predict_ctrl_pkg;

  localparam int DEF_IDX_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST) ? ST : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_table.sv
// rtl/branch_predict_ctrl_bht_table.sv - direct-mapped table of 2-bit saturating counters
import branch_predict_ctrl_pkg::*;

module bht_table #(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr [2**IDX_W];

  // Read is asynchronous and sees the pre-update value on a same-index collision.
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= WNT;
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - branch prediction lookup, EX-stage resolve, redirect/flush and event counters
import branch_predict_ctrl_pkg::*;

module branch_predict_ctrl #(
  parameter int IDX_W = DEF_IDX_W,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_stall,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             ex_actual_taken,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  state_t          state, state_nxt;
  logic            res, mis;
  logic [1:0]      rd_ctr;
  logic [PC_W-1:0] pc_plus4;
  logic            unused_bits;

  assign unused_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], rd_ctr[0]};

  bht_table #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (res & ~rst),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (ex_actual_taken)
  );

  assign if_pred_taken = rd_ctr[1];

  // The slot seen in RECOVER is wrong-path and must never resolve.
  assign res      = ex_valid & ex_is_branch & ~ex_stall & (state == RUN);
  assign mis      = res & (ex_pred_taken != ex_actual_taken);
  assign pc_plus4 = ex_pc + PC_W'(4);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mis) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    redirect    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    redirect_pc = pc_plus4;
    if (rst) begin
      redirect_pc = '0;
    end else if (mis) begin
      redirect    = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      redirect_pc = ex_actual_taken ? ex_target : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (res) branch_count     <= branch_count + CNT_W'(1);
      if (mis) mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed vector table plus randomized model check for branch_predict_ctrl
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_stall;
  logic [31:0] ex_pc, ex_target;
  logic        ex_pred_taken, ex_actual_taken;
  logic        redirect, flush_if_id, flush_id_ex;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_actual_taken  (ex_actual_taken),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic        r;
    logic [31:0] ipc;
    logic        v, br, st;
    logic [31:0] pc, tgt;
    logic        pt, at;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_pred;
    logic [31:0] e_bc, e_mc;
  } vec_t;

  vec_t vq[$];

  // Reference state: plain integer counters and a recovering flag.
  int          m_ctr[16];
  bit          m_rec;
  logic [31:0] m_bc, m_mc;

  function automatic vec_t mk(logic r, logic [31:0] ipc, logic v, logic br, logic st,
                              logic [31:0] pc, logic [31:0] tgt, logic pt, logic at,
                              logic e_redir, logic [31:0] e_rpc, logic e_pred,
                              logic [31:0] e_bc, logic [31:0] e_mc);
    vec_t x;
    x.r = r; x.ipc = ipc; x.v = v; x.br = br; x.st = st; x.pc = pc; x.tgt = tgt;
    x.pt = pt; x.at = at; x.e_redir = e_redir; x.e_rpc = e_rpc; x.e_pred = e_pred;
    x.e_bc = e_bc; x.e_mc = e_mc;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.r; if_pc = x.ipc; ex_valid = x.v; ex_is_branch = x.br; ex_stall = x.st;
    ex_pc = x.pc; ex_target = x.tgt; ex_pred_taken = x.pt; ex_actual_taken = x.at;
  endtask

  task automatic check_outputs(input string tag, input vec_t x);
    check({tag, " redirect"},    {31'b0, redirect},    {31'b0, x.e_redir});
    check({tag, " flush_if_id"}, {31'b0, flush_if_id}, {31'b0, x.e_redir});
    check({tag, " flush_id_ex"}, {31'b0, flush_id_ex}, {31'b0, x.e_redir});
    if (x.e_redir || x.r) check({tag, " redirect_pc"}, redirect_pc, x.e_rpc);
    check({tag, " pred"},        {31'b0, if_pred_taken}, {31'b0, x.e_pred});
    check({tag, " branch_count"}, branch_count, x.e_bc);
    check({tag, " mispredict_count"}, mispredict_count, x.e_mc);
  endtask

  // Fill in expectations for stimulus x from the model state before the edge.
  function automatic vec_t model_expect(vec_t xi);
    vec_t x = xi;
    bit res, mis;
    logic [31:0] plus4;
    res   = !x.r && x.v && x.br && !x.st && !m_rec;
    mis   = res && (x.pt != x.at);
    plus4 = x.pc + 32'd4;
    x.e_redir = mis;
    x.e_rpc   = x.r ? 32'd0 : (x.at ? x.tgt : plus4);
    x.e_pred  = (m_ctr[x.ipc[5:2]] >= 2);
    x.e_bc    = m_bc;
    x.e_mc    = m_mc;
    return x;
  endfunction

  task automatic model_step(input vec_t x);
    bit res, mis;
    int i;
    if (x.r) begin
      for (int k = 0; k < 16; k++) m_ctr[k] = 1;
      m_rec = 0; m_bc = 0; m_mc = 0;
    end else begin
      res = x.v && x.br && !x.st && !m_rec;
      mis = res && (x.pt != x.at);
      if (res) begin
        i = int'(x.pc[5:2]);
        m_ctr[i] = x.at ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        m_bc = m_bc + 1;
        if (mis) m_mc = m_mc + 1;
      end
      m_rec = mis;
    end
  endtask

  initial begin
    vec_t x;
    rst = 1'b1; if_pc = '0; ex_valid = 0; ex_is_branch = 0; ex_stall = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_actual_taken = 0;
    repeat (2) @(posedge clk);

    //        r  if_pc   v  br st ex_pc        tgt       pt at  redir rpc       pred bc  mc
    vq.push_back(mk(1, 32'h10, 1, 1, 0, 32'h10,       32'h40,   0, 1,  0, 32'h0,  0,  0,  0));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   0, 1,  1, 32'h40, 0,  0,  0));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   0, 1,  0, 32'h0,  1,  1,  1));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   1, 1,  0, 32'h0,  1,  1,  1));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   1, 1,  0, 32'h0,  1,  2,  1));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   1, 1,  0, 32'h0,  1,  3,  1));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   1, 1,  0, 32'h0,  1,  4,  1));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   1, 0,  1, 32'h14, 1,  5,  1));
    vq.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,  1,  6,  2));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   0, 0,  0, 32'h0,  1,  6,  2));
    vq.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,  0,  7,  2));
    vq.push_back(mk(0, 32'h20, 1, 1, 1, 32'h20,       32'h80,   0, 1,  0, 32'h0,  0,  7,  2));
    vq.push_back(mk(0, 32'h20, 1, 1, 1, 32'h20,       32'h80,   0, 1,  0, 32'h0,  0,  7,  2));
    vq.push_back(mk(0, 32'h20, 1, 1, 1, 32'h20,       32'h80,   0, 1,  0, 32'h0,  0,  7,  2));
    vq.push_back(mk(0, 32'h20, 1, 1, 0, 32'h20,       32'h80,   0, 1,  1, 32'h80, 0,  7,  2));
    vq.push_back(mk(0, 32'h20, 0, 0, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,  1,  8,  3));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h50,       32'h90,   1, 1,  0, 32'h0,  0,  8,  3));
    vq.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,  1,  9,  3));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'hFFFFFFFC, 32'h1234, 1, 0,  1, 32'h0,  1,  9,  3));
    vq.push_back(mk(1, 32'h10, 1, 1, 0, 32'h10,       32'h40,   0, 1,  0, 32'h0,  1, 10,  4));
    vq.push_back(mk(0, 32'h10, 1, 1, 0, 32'h10,       32'h40,   0, 1,  1, 32'h40, 0,  0,  0));
    vq.push_back(mk(0, 32'h3C, 0, 0, 0, 32'h0,        32'h0,    0, 0,  0, 32'h0,  0,  1,  1));

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check_outputs($sformatf("vec%0d", i), vq[i]);
    end

    for (int k = 0; k < 16; k++) m_ctr[k] = 1;
    m_rec = 0; m_bc = 0; m_mc = 0;
    @(negedge clk);
    x = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(x);
    @(posedge clk);

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      x.r   = ($urandom_range(0, 63) == 0);
      x.ipc = ($urandom_range(0, 7) == 0) ? $urandom : {24'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      x.v   = ($urandom_range(0, 3) != 0);
      x.br  = ($urandom_range(0, 3) != 0);
      x.st  = ($urandom_range(0, 3) == 0);
      x.pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {24'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      x.tgt = $urandom;
      x.pt  = 1'($urandom_range(0, 1));
      x.at  = 1'($urandom_range(0, 1));
      x = model_expect(x);
      drive(x);
      #1;
      check_outputs($sformatf("rnd%0d", n), x);
      @(posedge clk);
      model_step(x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
